// File: rtl/ram512_loader_pkg.sv
// rtl/ram512_loader_pkg.sv - shared constants and state encoding for the RAM512 loader
package ram512_loader_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 16;
  localparam int RAM_DEPTH  = 512;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/ram512_loader_addr_walker.sv
// rtl/ram512_loader_addr_walker.sv - wrapping address counter with remaining-word down-counter
module addr_walker #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W:0]   load_count,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W:0] remaining;

  // load wins over step so the top can reload on the final write beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= load_count;
    end else if (step) begin
      addr      <= addr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

  assign last = (remaining == {{ADDR_W{1'b0}}, 1'b1});

endmodule

// File: rtl/ram512_loader.sv
// rtl/ram512_loader.sv - fills or clears a RAM512 region from a word stream, then verifies it
module ram512_loader
  import ram512_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  // Full bank size; larger requests collapse to this.
  localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic              clear_q;
  logic [DATA_W-1:0] wsum, rsum, checksum_q;
  logic              error_q;

  logic [ADDR_W:0]   count_clamped;
  logic              accept;
  logic              write_beat;
  logic              load_raw;

  logic              wk_load, wk_step, wk_last;
  logic [ADDR_W-1:0] wk_addr_in, wk_addr;
  logic [ADDR_W:0]   wk_count_in;

  assign count_clamped = (count > MAX_COUNT) ? MAX_COUNT : count;

  addr_walker #(.ADDR_W(ADDR_W)) u_walker (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (wk_load),
    .load_addr  (wk_addr_in),
    .load_count (wk_count_in),
    .step       (wk_step),
    .addr       (wk_addr),
    .last       (wk_last)
  );

  // next state, walker control and RAM-side outputs
  always_comb begin
    state_nx    = state;
    wk_load     = 1'b0;
    wk_step     = 1'b0;
    wk_addr_in  = base_q;
    wk_count_in = count_q;
    accept      = 1'b0;
    write_beat  = 1'b0;
    load_raw    = 1'b0;
    s_ready     = 1'b0;
    ram_in      = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done     = (state == S_DONE);
        state_nx = S_IDLE;
        if (start) begin
          accept      = 1'b1;
          wk_load     = 1'b1;
          wk_addr_in  = base;
          wk_count_in = count_clamped;
          state_nx    = (count_clamped == '0) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        busy       = 1'b1;
        s_ready    = !clear_q;
        ram_in     = clear_q ? '0 : s_data;
        write_beat = clear_q || s_valid;
        load_raw   = write_beat;
        wk_step    = write_beat;
        if (write_beat && wk_last) begin
          // rewind to base for the verify pass
          wk_load  = 1'b1;
          state_nx = S_VERIFY;
        end
      end
      S_VERIFY: begin
        busy    = 1'b1;
        wk_step = 1'b1;
        if (wk_last) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // reset must block RAM writes even in the very cycle it is asserted
  assign ram_load    = load_raw && rst_n;
  assign ram_address = wk_addr;
  assign error       = error_q;
  assign checksum    = checksum_q;

  // state register, operation parameters, running sums and result flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      clear_q    <= 1'b0;
      wsum       <= '0;
      rsum       <= '0;
      checksum_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        base_q     <= base;
        count_q    <= count_clamped;
        clear_q    <= clear;
        wsum       <= '0;
        rsum       <= '0;
        checksum_q <= '0;
        error_q    <= 1'b0;
      end
      if (write_beat) wsum <= wsum + ram_in;
      if (state == S_VERIFY) begin
        rsum <= rsum + ram_out;
        if (wk_last) begin
          error_q    <= ((rsum + ram_out) != wsum);
          checksum_q <= wsum;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram512_loader.sv
// tb/tb_ram512_loader.sv - directed self-checking bench for ram512_loader with a RAM512 model
module tb_ram512_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, clear;
  logic [8:0]  base;
  logic [9:0]  count;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready, ram_load, busy, done, error;
  logic [8:0]  ram_address;
  logic [15:0] ram_in, ram_out, checksum;

  logic [15:0] mem [0:511];
  logic        force_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] src      [0:31];
  logic [8:0]  log_addr [0:63];
  logic [15:0] log_data [0:63];
  int          stall_load_bad;

  always #5 clk = ~clk;

  ram512_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .clear       (clear),
    .base        (base),
    .count       (count),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .ram_load    (ram_load),
    .ram_address (ram_address),
    .ram_in      (ram_in),
    .ram_out     (ram_out),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .checksum    (checksum)
  );

  // RAM512 model: synchronous write, asynchronous read
  assign ram_out = mem[ram_address] | {15'd0, force_err};
  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;

  // Runs one operation from the idle state; cycle k counts edges after E0.
  task automatic run_op(input logic [8:0] b, input logic [9:0] c, input logic clr,
                        input int stall_idx, input int stall_len, input bit pulse,
                        output int done_cyc, output int nwr);
    int widx;
    int stalls;
    bit stalled;
    nwr = 0; done_cyc = -1; widx = 0; stalls = stall_len; stall_load_bad = 0;
    base = b; count = c; clear = clr; start = 1'b1; s_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    for (int k = 1; k <= 2000; k++) begin
      if (pulse && busy) begin
        start = 1'b1; clear = 1'b1; base = 9'd0; count = 10'd5;
      end else begin
        start = 1'b0; clear = 1'b0;
      end
      stalled = 1'b0;
      if (s_ready && widx == stall_idx && stalls > 0) begin
        s_valid = 1'b0; stalls--; stalled = 1'b1;
      end else begin
        s_valid = 1'b1; s_data = src[widx % 32];
      end
      #1;
      if (stalled && ram_load) stall_load_bad++;
      if (ram_load && nwr < 64) begin
        log_addr[nwr] = ram_address; log_data[nwr] = ram_in; nwr++;
      end
      if (s_valid && s_ready) widx++;
      if (done) begin done_cyc = k; break; end
      @(posedge clk); #1;
    end
    s_valid = 1'b0; start = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 0; clear = 0; base = 0; count = 0; s_valid = 0; s_data = 0;
    force_err = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, error, s_ready, ram_load} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, error, s_ready, ram_load});
    end
    n_checks++;
    if (ram_address !== 9'd0 || ram_in !== 16'd0 || checksum !== 16'd0) begin
      n_fail++; $display("FAIL reset_buses: got addr=%0h in=%0h sum=%0h expected 0", ram_address, ram_in, checksum);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_load_basic;
    int d, n;
    for (int i = 0; i < 4; i++) src[i] = 16'(i + 1);
    run_op(9'd0, 10'd4, 1'b0, -1, 0, 1'b0, d, n);
    n_checks++;
    if (d !== 9) begin n_fail++; $display("FAIL load_done_cycle: got %0d expected 9", d); end
    n_checks++;
    if (n !== 4) begin n_fail++; $display("FAIL load_writes: got %0d expected 4", n); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL load_busy_at_done: got %b expected 0", busy); end
    n_checks++;
    if (checksum !== 16'h000A || error !== 1'b0) begin
      n_fail++; $display("FAIL load_result: got sum=%h err=%b expected 000a 0", checksum, error);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem[i] !== 16'(i + 1)) begin n_fail++; $display("FAIL load_mem[%0d]: got %h expected %h", i, mem[i], 16'(i + 1)); end
    end
  endtask

  task automatic test_wrap;
    int d, n;
    logic [8:0] exp_a [0:3];
    exp_a[0] = 9'd510; exp_a[1] = 9'd511; exp_a[2] = 9'd0; exp_a[3] = 9'd1;
    for (int i = 0; i < 4; i++) src[i] = 16'hFFFF;
    run_op(9'd510, 10'd4, 1'b0, -1, 0, 1'b0, d, n);
    n_checks++;
    if (d !== 9 || n !== 4) begin n_fail++; $display("FAIL wrap_timing: got done=%0d writes=%0d expected 9 4", d, n); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (log_addr[i] !== exp_a[i]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, log_addr[i], exp_a[i]); end
    end
    n_checks++;
    if (checksum !== 16'hFFFC || error !== 1'b0) begin
      n_fail++; $display("FAIL wrap_result: got sum=%h err=%b expected fffc 0", checksum, error);
    end
  endtask

  task automatic test_stall;
    int d, n;
    src[0] = 16'h0011; src[1] = 16'h0022; src[2] = 16'h0033;
    run_op(9'd100, 10'd3, 1'b0, 1, 2, 1'b0, d, n);
    n_checks++;
    if (d !== 9) begin n_fail++; $display("FAIL stall_done_cycle: got %0d expected 9", d); end
    n_checks++;
    if (n !== 3) begin n_fail++; $display("FAIL stall_writes: got %0d expected 3", n); end
    n_checks++;
    if (stall_load_bad !== 0) begin n_fail++; $display("FAIL stall_load: got %0d loads in stall cycles expected 0", stall_load_bad); end
    n_checks++;
    if (checksum !== 16'h0066 || mem[101] !== 16'h0022) begin
      n_fail++; $display("FAIL stall_result: got sum=%h mem101=%h expected 0066 0022", checksum, mem[101]);
    end
  endtask

  task automatic test_clear;
    int d, n;
    for (int i = 0; i < 8; i++) src[i] = 16'h1234;
    run_op(9'd0, 10'd8, 1'b0, -1, 0, 1'b0, d, n);
    n_checks++;
    if (mem[7] !== 16'h1234 || checksum !== 16'h91A0) begin
      n_fail++; $display("FAIL preload: got mem7=%h sum=%h expected 1234 91a0", mem[7], checksum);
    end
    run_op(9'd0, 10'd8, 1'b1, -1, 0, 1'b0, d, n);
    n_checks++;
    if (d !== 17 || n !== 8) begin n_fail++; $display("FAIL clear_timing: got done=%0d writes=%0d expected 17 8", d, n); end
    n_checks++;
    if (checksum !== 16'h0 || error !== 1'b0) begin
      n_fail++; $display("FAIL clear_result: got sum=%h err=%b expected 0000 0", checksum, error);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (mem[i] !== 16'h0) begin n_fail++; $display("FAIL clear_mem[%0d]: got %h expected 0000", i, mem[i]); end
    end
  endtask

  task automatic test_clamp;
    int d, n;
    run_op(9'd0, 10'd1023, 1'b1, -1, 0, 1'b0, d, n);
    n_checks++;
    if (d !== 1025) begin n_fail++; $display("FAIL clamp_done_cycle: got %0d expected 1025", d); end
  endtask

  task automatic test_error_and_busy;
    int d, n;
    force_err = 1'b1;
    src[0] = 16'h0002; src[1] = 16'h0004;
    run_op(9'h40, 10'd2, 1'b0, -1, 0, 1'b1, d, n);
    force_err = 1'b0;
    n_checks++;
    if (d !== 5) begin n_fail++; $display("FAIL err_done_cycle: got %0d expected 5", d); end
    n_checks++;
    if (error !== 1'b1) begin n_fail++; $display("FAIL err_at_done: got %b expected 1", error); end
    n_checks++;
    if (mem[9'h40] !== 16'h0002 || mem[9'h41] !== 16'h0004 || checksum !== 16'h0006) begin
      n_fail++; $display("FAIL busy_start_ignored: got m40=%h m41=%h sum=%h expected 0002 0004 0006",
                         mem[9'h40], mem[9'h41], checksum);
    end
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (error !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", error); end
    run_op(9'd0, 10'd0, 1'b0, -1, 0, 1'b0, d, n);
    n_checks++;
    if (error !== 1'b0 || d !== 1 || n !== 0) begin
      n_fail++; $display("FAIL err_cleared: got err=%b done=%0d writes=%0d expected 0 1 0", error, d, n);
    end
  endtask

  task automatic test_reset_mid_write;
    int d, n;
    mem[9'h22] = 16'hBEEF;
    base = 9'h20; count = 10'd4; clear = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_valid = 1'b1; s_data = 16'(16'hA0 + k);
      @(posedge clk); #1;
    end
    s_valid = 1'b1; s_data = 16'h00A2; rst_n = 1'b0;
    #1;
    n_checks++;
    if (ram_load !== 1'b0) begin n_fail++; $display("FAIL rst_gates_load: got %b expected 0", ram_load); end
    @(posedge clk); #1;
    rst_n = 1'b1; s_valid = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, error, s_ready, ram_load} !== 5'b0 || ram_address !== 9'd0 || ram_in !== 16'd0 || checksum !== 16'd0) begin
      n_fail++; $display("FAIL rst_outputs: got flags=%b addr=%0h in=%0h sum=%0h expected all 0",
                         {busy, done, error, s_ready, ram_load}, ram_address, ram_in, checksum);
    end
    n_checks++;
    if (mem[9'h20] !== 16'h00A0 || mem[9'h21] !== 16'h00A1 || mem[9'h22] !== 16'hBEEF) begin
      n_fail++; $display("FAIL rst_mem: got %h %h %h expected 00a0 00a1 beef", mem[9'h20], mem[9'h21], mem[9'h22]);
    end
    run_op(9'd0, 10'd0, 1'b0, -1, 0, 1'b0, d, n);
    n_checks++;
    if (d !== 1 || n !== 0) begin n_fail++; $display("FAIL rst_count0: got done=%0d writes=%0d expected 1 0", d, n); end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_wrap();
    test_stall();
    test_clear();
    test_clamp();
    test_error_and_busy();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram512_loader.md
# ram512_loader

Sequencing front-end that fills a RAM512 bank from a valid/ready word stream, or clears it, then reads the written region back to verify it. Sits directly upstream of RAM512 and drives its `load`, `address` and `in` ports while observing `out`. Used for program/data preload at boot and as a self-check stage in the memory benches.

## Interface

Parameters:
- `ADDR_W`, 9: RAM address width (512 words).
- `DATA_W`, 16: word width.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: begin an operation; sampled only when `busy`=0.
- `clear` in 1: sampled with `start`; 1 = clear mode (write zeros), 0 = load mode.
- `base` in ADDR_W: first RAM address; latched on accepted `start`.
- `count` in ADDR_W+1: number of words, 0..512; values >512 are treated as 512; latched on `start`.
- `s_valid` in 1: upstream word valid.
- `s_data` in DATA_W: upstream word.
- `s_ready` out 1: loader accepts `s_data` this cycle.
- `ram_load` out 1: to RAM512 `load`.
- `ram_address` out ADDR_W: to RAM512 `address`.
- `ram_in` out DATA_W: to RAM512 `in`.
- `ram_out` in DATA_W: from RAM512 `out`; asynchronous read of `ram_address`.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: verify mismatch; sticky until the next accepted `start`.
- `checksum` out DATA_W: mod-2^16 sum of words written by the last operation.

## Operation

- States: IDLE, WRITE, VERIFY, DONE.
- IDLE: `busy`=0, `s_ready`=0, `ram_load`=0. On `start`=1: latch `base`, clamped `count`, mode; clear `checksum`, `error`, write and read sums; go to WRITE, or to DONE if `count`=0.
- WRITE, load mode: `s_ready`=1. `ram_load` = `s_valid`; `ram_in` = `s_data`; `ram_address` = current address. Each beat with `s_valid`&&`s_ready` writes one word, adds it to the write sum, advances the address and decrements the remaining count. After the last beat, go to VERIFY.
- WRITE, clear mode: `s_ready`=0, `s_*` ignored. `ram_load`=1 and `ram_in`=0 every cycle, one word per cycle.
- Address arithmetic is ADDR_W bits and wraps 511→0. A region with `base`=500 and `count`=20 covers 500..511 then 0..7.
- VERIFY: `ram_load`=0. Address restarts at `base` and walks `count` words, one per cycle. Each cycle adds `ram_out` to the read sum, mod 2^16. After the last word, `error` = (read sum ≠ write sum); go to DONE.
- DONE: `done`=1 for one cycle, `checksum` = write sum; return to IDLE.
- `start` while `busy`=1 is ignored. `start` and `clear` asserted in the same cycle selects clear mode.
- Reset: all outputs 0 and state IDLE after the reset edge. `ram_load` is additionally gated combinationally by `rst_n`, so no RAM write occurs during any cycle with `rst_n`=0, including mid-WRITE.

## Timing

- Edge E0 accepts `start`. The first write edge is E1 if `s_valid`=1 in that cycle.
- Load mode with no stalls, or clear mode: WRITE spans `count` cycles and VERIFY spans `count` cycles. `done` is high in cycle 2·`count`+1 after E0, and `busy` falls with it.
- Each upstream stall (`s_valid`=0 in WRITE) adds exactly one cycle.
- `count`=0: `done` is high in the cycle after E0; no RAM writes.
- `checksum` and `error` are valid from the `done` cycle and hold until the next accepted `start`.
- `s_ready` is a function of state only; there is no combinational path from `s_valid` to `s_ready`.

## Structure

- Shared include header (alongside `memory.v`) holds: state encodings, `ADDR_W`/`DATA_W` defaults, and the RAM512 depth constant (512).
- One natural sub-module, `addr_walker`: loadable ADDR_W-bit wrapping address counter plus remaining-count down-counter with a `last` flag. It is instantiated once and reloaded for VERIFY.
- RAM512 is not instantiated inside the loader; the bench and the top level wire the two together.

## Test plan

- Load mode, `base`=0, `count`=4, stream 0x0001..0x0004 without stalls -> RAM[0..3] = 1..4; `done` in cycle 9 after E0; `checksum`=0x000A; `error`=0.
- Load mode, `base`=510, `count`=4, words 0xFFFF ×4 -> writes at 510, 511, 0, 1; `checksum`=0xFFFC; address never exceeds 511.
- Load mode, `count`=3 with `s_valid` low for 2 cycles mid-stream -> exactly 3 writes; `done` 2 cycles later than the unstalled case; `ram_load`=0 during stalls.
- Clear mode after a prior load of 0x1234 at 0..7, `base`=0, `count`=8 -> RAM[0..7]=0; `checksum`=0; `error`=0.
- Bench forces `ram_out` bit 0 high during VERIFY -> `error`=1 at `done`, held until the next `start`; `start` pulses while `busy`=1 are ignored.
- `rst_n` low for one cycle in the middle of WRITE -> no write in that cycle; all outputs 0 afterwards; a fresh `start` with `count`=0 gives `done` in the next cycle.
